// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage
//
// Memory / writeback pipeline stage. Accepts one op at a time from the
// execute stage. ALU ops go straight to writeback on the following cycle.
// Loads and stores first perform a memory handshake, holding the request
// until mem_ack. A load then writes back the data returned by memory.
// A request that waits too long is aborted and raises a sticky error.
//
// Parameters
//   W        datapath width
//   D        register-address width
//   TIMEOUT  maximum cycles spent in MEM waiting for mem_ack (must be >= 1)
//
// Ports
//   CLK, RST_N       rising-edge clock, asynchronous active-low reset
//   in_valid/ready   op handshake from the execute stage
//   in_waddr         destination register
//   in_alu           ALU result
//   in_is_load/store op kind (both set is illegal and is dropped)
//   in_addr/in_sdata memory address and store data
//   mem_req/we       memory request strobe and direction (1 = store)
//   mem_addr/wdata   request address and store data, stable while in MEM
//   mem_ack/rdata    completion strobe and load data
//   wb_write_en      single-cycle register-file write strobe
//   wb_waddr         register-file write address
//   wb_data_alu/mem  candidate writeback values
//   wb_data_source   1 selects wb_data_mem
//   err              sticky error (illegal op or memory timeout)
// ============================================================================
module mem_wb_stage #(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] in_waddr,
    input  logic [W-1:0] in_alu,
    input  logic         in_is_load,
    input  logic         in_is_store,
    input  logic [W-1:0] in_addr,
    input  logic [W-1:0] in_sdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_rdata,
    output logic         wb_write_en,
    output logic [D-1:0] wb_waddr,
    output logic [W-1:0] wb_data_alu,
    output logic [W-1:0] wb_data_mem,
    output logic         wb_data_source,
    output logic         err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  wait_cnt_reg;
    logic           mem_req_reg;
    logic           mem_we_reg;
    logic [W-1:0]   mem_addr_reg;
    logic [W-1:0]   mem_wdata_reg;
    logic [D-1:0]   pend_waddr_reg;
    logic           wb_write_en_reg;
    logic [D-1:0]   wb_waddr_reg;
    logic [W-1:0]   wb_data_alu_reg;
    logic [W-1:0]   wb_data_mem_reg;
    logic           wb_data_source_reg;
    logic           err_reg;

    logic           accept;
    logic           last_wait;

    assign in_ready = (state_reg == IDLE);
    assign accept   = in_valid && in_ready;

    // The counter holds the number of ack-less MEM cycles already elapsed,
    // so a miss in this cycle is the TIMEOUT-th one and ends the wait.
    assign last_wait = (wait_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg          <= IDLE;
            wait_cnt_reg       <= '0;
            mem_req_reg        <= 1'b0;
            mem_we_reg         <= 1'b0;
            mem_addr_reg       <= '0;
            mem_wdata_reg      <= '0;
            pend_waddr_reg     <= '0;
            wb_write_en_reg    <= 1'b0;
            wb_waddr_reg       <= '0;
            wb_data_alu_reg    <= '0;
            wb_data_mem_reg    <= '0;
            wb_data_source_reg <= 1'b0;
            err_reg            <= 1'b0;
        end else begin
            // Write strobe is a pulse; the data/address registers hold.
            wb_write_en_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // mem_ack is deliberately not looked at here.
                    if (accept) begin
                        if (in_is_load && in_is_store) begin
                            err_reg <= 1'b1;
                        end else if (in_is_load || in_is_store) begin
                            state_reg      <= MEM;
                            wait_cnt_reg   <= '0;
                            mem_req_reg    <= 1'b1;
                            mem_we_reg     <= in_is_store;
                            mem_addr_reg   <= in_addr;
                            mem_wdata_reg  <= in_sdata;
                            pend_waddr_reg <= in_waddr;
                        end else begin
                            wb_write_en_reg    <= (in_waddr != '0);
                            wb_waddr_reg       <= in_waddr;
                            wb_data_alu_reg    <= in_alu;
                            wb_data_source_reg <= 1'b0;
                        end
                    end
                end

                MEM: begin
                    if (mem_ack) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        if (!mem_we_reg) begin
                            wb_write_en_reg    <= (pend_waddr_reg != '0);
                            wb_waddr_reg       <= pend_waddr_reg;
                            wb_data_mem_reg    <= mem_rdata;
                            wb_data_source_reg <= 1'b1;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        if (last_wait) begin
                            state_reg   <= IDLE;
                            mem_req_reg <= 1'b0;
                            err_reg     <= 1'b1;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_req        = mem_req_reg;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign wb_write_en    = wb_write_en_reg;
    assign wb_waddr       = wb_waddr_reg;
    assign wb_data_alu    = wb_data_alu_reg;
    assign wb_data_mem    = wb_data_mem_reg;
    assign wb_data_source = wb_data_source_reg;
    assign err            = err_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage
//
// Self-checking bench for mem_wb_stage. Ops are issued as transactions;
// the bench predicts each outcome (writeback or not, memory request
// duration, error flag, held writeback values) from the stage's rules.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ============================================================================
module tb_mem_wb_stage;

    localparam int W       = 8;
    localparam int D       = 4;
    localparam int TIMEOUT = 15;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_waddr;
    logic [W-1:0] in_alu;
    logic         in_is_load;
    logic         in_is_store;
    logic [W-1:0] in_addr;
    logic [W-1:0] in_sdata;
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_ack;
    logic [W-1:0] mem_rdata;
    logic         wb_write_en;
    logic [D-1:0] wb_waddr;
    logic [W-1:0] wb_data_alu;
    logic [W-1:0] wb_data_mem;
    logic         wb_data_source;
    logic         err;

    mem_wb_stage #(.W(W), .D(D), .TIMEOUT(TIMEOUT)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_waddr       (in_waddr),
        .in_alu         (in_alu),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_addr        (in_addr),
        .in_sdata       (in_sdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .wb_write_en    (wb_write_en),
        .wb_waddr       (wb_waddr),
        .wb_data_alu    (wb_data_alu),
        .wb_data_mem    (wb_data_mem),
        .wb_data_source (wb_data_source),
        .err            (err)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: what the writeback outputs and error flag must show.
    logic         exp_err;
    logic [D-1:0] m_waddr;
    logic [W-1:0] m_alu;
    logic [W-1:0] m_mem;
    logic         m_src;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        exp_err = 1'b0;
        m_waddr = '0;
        m_alu   = '0;
        m_mem   = '0;
        m_src   = 1'b0;
    endtask

    task automatic check_hold(input string tag);
        check({tag, ".wb_waddr"}, wb_waddr, m_waddr);
        check({tag, ".wb_data_alu"}, wb_data_alu, m_alu);
        check({tag, ".wb_data_mem"}, wb_data_mem, m_mem);
        check({tag, ".wb_data_source"}, wb_data_source, m_src);
        check({tag, ".err"}, err, exp_err);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".mem_req"}, mem_req, 0);
        check({tag, ".mem_we"}, mem_we, 0);
        check({tag, ".mem_addr"}, mem_addr, 0);
        check({tag, ".mem_wdata"}, mem_wdata, 0);
        check({tag, ".wb_write_en"}, wb_write_en, 0);
        check({tag, ".in_ready"}, in_ready, 1);
        check_hold(tag);
    endtask

    // One cycle with no op; mem_ack may be toggled and must be ignored.
    task automatic idle_cycle(input logic noise);
        mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = W'($urandom);
        @(negedge CLK);
        mem_ack = 1'b0;
        check("idle.wb_write_en", wb_write_en, 0);
        check("idle.mem_req", mem_req, 0);
        check("idle.in_ready", in_ready, 1);
        check_hold("idle");
    endtask

    task automatic run_alu(input logic [D-1:0] waddr, input logic [W-1:0] alu);
        check("alu.in_ready", in_ready, 1);
        in_valid    = 1'b1;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_waddr    = waddr;
        in_alu      = alu;
        in_addr     = W'($urandom);
        in_sdata    = W'($urandom);
        @(negedge CLK);
        in_valid = 1'b0;
        m_waddr = waddr;
        m_alu   = alu;
        m_src   = 1'b0;
        check("alu.wb_write_en", wb_write_en, (waddr != 0));
        check("alu.mem_req", mem_req, 0);
        check_hold("alu");
        $display("ALU   waddr=%0d alu=0x%02h wb_write_en=%0b", waddr, alu, wb_write_en);
    endtask

    // lat = MEM cycle (1-based) in which mem_ack is given, 0 = never.
    task automatic run_mem(input logic ld, input logic st, input logic [D-1:0] waddr,
                           input logic [W-1:0] addr, input logic [W-1:0] sdata,
                           input int lat, input logic [W-1:0] rdata);
        int cycles;
        check("mem.in_ready", in_ready, 1);
        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_waddr    = waddr;
        in_alu      = W'($urandom);
        in_addr     = addr;
        in_sdata    = sdata;
        @(negedge CLK);
        in_valid = 1'b0;
        if (ld && st) begin
            exp_err = 1'b1;
            check("ill.mem_req", mem_req, 0);
            check("ill.wb_write_en", wb_write_en, 0);
            check("ill.in_ready", in_ready, 1);
            check_hold("ill");
            $display("ILL   waddr=%0d dropped err=%0b", waddr, err);
            return;
        end
        cycles = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            cycles = i;
            check("mem.req_high", mem_req, 1);
            check("mem.in_ready_low", in_ready, 0);
            check("mem.addr", mem_addr, addr);
            check("mem.we", mem_we, st);
            check("mem.wdata", mem_wdata, sdata);
            check("mem.wb_idle", wb_write_en, 0);
            if (lat == i) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_rdata = W'($urandom);
            end
            @(negedge CLK);
            mem_ack   = 1'b0;
            mem_rdata = W'($urandom);
            if (lat == i) begin
                if (ld) begin
                    m_waddr = waddr;
                    m_mem   = rdata;
                    m_src   = 1'b1;
                end
                check("ack.wb_write_en", wb_write_en, ld && (waddr != 0));
                check("ack.mem_req", mem_req, 0);
                check("ack.in_ready", in_ready, 1);
                check_hold("ack");
                break;
            end
            if (lat == 0 && i == TIMEOUT) begin
                exp_err = 1'b1;
                check("tmo.mem_req", mem_req, 0);
                check("tmo.wb_write_en", wb_write_en, 0);
                check("tmo.in_ready", in_ready, 1);
                check_hold("tmo");
                break;
            end
        end
        $display("%s waddr=%0d addr=0x%02h sdata=0x%02h req_cycles=%0d %s rdata=0x%02h err=%0b",
                 st ? "STORE" : "LOAD ", waddr, addr, sdata, cycles,
                 (lat == 0) ? "timeout" : "acked", rdata, err);
    endtask

    task automatic pulse_reset();
        #2 RST_N = 1'b0;
        model_reset();
        #1 check_reset_values("rst");
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1 check("rst.release_ready", in_ready, 1);
        @(negedge CLK);
        check("rst.first_cycle_ready", in_ready, 1);
        $display("RESET pulsed, outputs cleared");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N       = 1'b0;
        in_valid    = 1'b0;
        in_waddr    = '0;
        in_alu      = '0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_addr     = '0;
        in_sdata    = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        model_reset();

        // Reset values appear before any clock edge.
        #3 check_reset_values("por");
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1 check("por.release_ready", in_ready, 1);
        @(negedge CLK);

        // Directed cases.
        run_alu(4'd3, 8'h5A);
        idle_cycle(1'b0);
        run_mem(1'b1, 1'b0, 4'd5, 8'h10, 8'h00, 3, 8'hC3);
        idle_cycle(1'b0);
        run_mem(1'b0, 1'b1, 4'd2, 8'h20, 8'h77, 1, 8'h00);
        run_alu(4'd0, 8'h11);
        idle_cycle(1'b0);
        run_alu(4'd1, 8'hA1);
        run_alu(4'd2, 8'hA2);
        run_alu(4'd3, 8'hA3);
        idle_cycle(1'b1);
        // Load immediately followed by an ALU op: two writebacks in order.
        run_mem(1'b1, 1'b0, 4'd7, 8'h33, 8'h44, 2, 8'h9E);
        run_alu(4'd8, 8'h81);
        idle_cycle(1'b0);
        run_mem(1'b1, 1'b0, 4'd6, 8'h40, 8'h00, 0, 8'h00);
        for (int k = 0; k < 3; k++) idle_cycle(1'b1);
        pulse_reset();
        run_mem(1'b1, 1'b1, 4'd4, 8'h50, 8'h51, 1, 8'h00);
        idle_cycle(1'b0);
        pulse_reset();

        // Reset in the middle of a load: op discarded, late ack ignored.
        in_valid    = 1'b1;
        in_is_load  = 1'b1;
        in_is_store = 1'b0;
        in_waddr    = 4'd9;
        in_addr     = 8'h66;
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        check("midrst.req_before", mem_req, 1);
        pulse_reset();
        for (int k = 0; k < 4; k++) idle_cycle(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            int kind;
            kind = $urandom_range(0, 39);
            if (kind < 16)
                run_alu(D'($urandom), W'($urandom));
            else if (kind < 26)
                run_mem(1'b1, 1'b0, D'($urandom), W'($urandom), W'($urandom),
                        $urandom_range(1, 10), W'($urandom));
            else if (kind < 33)
                run_mem(1'b0, 1'b1, D'($urandom), W'($urandom), W'($urandom),
                        $urandom_range(1, 10), W'($urandom));
            else if (kind < 38)
                idle_cycle(1'b1);
            else if (kind == 38)
                run_mem(1'b1, 1'b0, D'($urandom), W'($urandom), W'($urandom),
                        0, W'($urandom));
            else
                run_mem(1'b1, 1'b1, D'($urandom), W'($urandom), W'($urandom),
                        1, W'($urandom));
        end
        idle_cycle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
